// File: rtl/pixel_window_buffer.sv
// Read-side line buffer: holds a 3x8 pixel window plus an 8-pixel staging row,
// and emits 3x3 neighbourhoods to the pixel filter one column at a time.
module pixel_window_buffer #(
  parameter int PIXEL_W  = 24,
  parameter int SEG_W    = 8,
  parameter int OUT_COLS = 6
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [31:0]          master_readdata,
  input  logic                 master_readdatavalid,
  input  logic                 shift_enable24,
  input  logic                 load_read_buffer,
  input  logic                 shift_enable8,
  input  logic                 pixel_enable,
  output logic                 done_read24,
  output logic                 done_load_read_buffer,
  output logic                 done_shift8,
  output logic [9*PIXEL_W-1:0] window_out,
  output logic                 window_valid,
  output logic [2:0]           col_index,
  output logic                 overrun_err
);

  logic [PIXEL_W-1:0] win   [3][SEG_W];
  logic [PIXEL_W-1:0] stage [SEG_W];
  logic [4:0]         fill_cnt;
  logic [2:0]         pf_cnt;
  logic [2:0]         col_ptr;
  logic               staging_full;
  logic               armed;

  logic [PIXEL_W-1:0] pixel_in;
  logic               fill_take, fill_last, shift_fire, pf_take, pf_drop;
  logic               unused_readdata;

  assign pixel_in        = master_readdata[PIXEL_W-1:0];
  assign unused_readdata = ^master_readdata[31:PIXEL_W];

  assign fill_take  = shift_enable24 && master_readdatavalid;
  assign fill_last  = fill_take && (fill_cnt == 5'(3*SEG_W-1));
  assign shift_fire = shift_enable8 && armed && staging_full;
  // A shift empties staging this cycle, so a concurrent prefetch word is kept as the new stage[0].
  assign pf_take    = master_readdatavalid && !shift_enable24 && load_read_buffer &&
                      (!staging_full || shift_fire);
  assign pf_drop    = master_readdatavalid && !shift_enable24 && !pf_take;

  assign done_load_read_buffer = staging_full;
  assign col_index             = col_ptr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < SEG_W; c++) win[r][c] <= '0;
      for (int c = 0; c < SEG_W; c++) stage[c] <= '0;
      fill_cnt     <= '0;
      pf_cnt       <= '0;
      col_ptr      <= '0;
      staging_full <= 1'b0;
      armed        <= 1'b0;
      done_read24  <= 1'b0;
      done_shift8  <= 1'b0;
      window_out   <= '0;
      window_valid <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      done_read24  <= fill_last;
      done_shift8  <= shift_fire;
      window_valid <= pixel_enable;
      if (pf_drop) overrun_err <= 1'b1;
      if (!shift_enable8) armed <= 1'b1;

      // Window read always sees pre-update contents; later col_ptr writes override the increment.
      if (pixel_enable) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            window_out[(r*3+c)*PIXEL_W +: PIXEL_W] <= win[r][col_ptr + 3'(c)];
        col_ptr <= (col_ptr == 3'(OUT_COLS-1)) ? 3'd0 : col_ptr + 3'd1;
      end

      if (shift_fire) begin
        for (int c = 0; c < SEG_W; c++) begin
          win[0][c] <= win[1][c];
          win[1][c] <= win[2][c];
          win[2][c] <= stage[c];
        end
        armed        <= 1'b0;
        staging_full <= 1'b0;
        pf_cnt       <= '0;
        col_ptr      <= '0;
      end

      if (pf_take) begin
        stage[shift_fire ? 3'd0 : pf_cnt] <= pixel_in;
        pf_cnt <= (shift_fire ? 3'd0 : pf_cnt) + 3'd1;
        if (!shift_fire && pf_cnt == 3'd7) staging_full <= 1'b1;
      end

      if (fill_take) begin
        win[fill_cnt[4:3]][fill_cnt[2:0]] <= pixel_in;
        if (fill_last) begin
          fill_cnt     <= '0;
          col_ptr      <= '0;
          staging_full <= 1'b0;
        end else begin
          fill_cnt <= fill_cnt + 5'd1;
        end
      end
    end
  end

endmodule
